// File: rtl/seg_scan_reader.sv
// Seven-segment scan bus reader: debounces each multiplexed digit,
// decodes glyphs back to hex and assembles 16-bit frames on valid/ready.
module seg_scan_reader #(
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_sel,
    output logic [15:0] out_data,
    output logic [3:0]  out_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    typedef enum logic {
        COLLECT,
        COMPLETE
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  seg_q, prev_seg_q;
    logic [3:0]  sel_q, prev_sel_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] slot_data_q, slot_data_d;
    logic [3:0]  slot_err_q, slot_err_d;
    logic [15:0] odata_q, odata_d;
    logic [3:0]  oerr_q, oerr_d;
    logic        ovalid_q, ovalid_d;
    logic        ovf_q, ovf_d;

    logic        onehot, same, accept, load;
    logic [3:0]  acc_bits;
    logic [4:0]  glyph;

    // Returns {err, nibble}; unknown patterns decode as 0 with err set.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h7E:   r = 5'h00;
            7'h30:   r = 5'h01;
            7'h6D:   r = 5'h02;
            7'h79:   r = 5'h03;
            7'h33:   r = 5'h04;
            7'h5B:   r = 5'h05;
            7'h5F:   r = 5'h06;
            7'h70:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h7B:   r = 5'h09;
            7'h77:   r = 5'h0A;
            7'h1F:   r = 5'h0B;
            7'h4E:   r = 5'h0C;
            7'h3D:   r = 5'h0D;
            7'h4F:   r = 5'h0E;
            7'h47:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    always_comb begin
        onehot = (sel_q != 4'd0) && ((sel_q & (sel_q - 4'd1)) == 4'd0);
        same   = (seg_q == prev_seg_q) && (sel_q == prev_sel_q);
        glyph  = decode(seg_q);
        cnt_d  = cnt_q;
        if (!onehot) begin
            cnt_d = 4'd0;
        end else if (!same) begin
            cnt_d = 4'd1;
        end else if (cnt_q < STABLE) begin
            cnt_d = cnt_q + 4'd1;
        end
        // A saturated run must not fire again.
        accept   = onehot && (cnt_d == STABLE) && !(same && cnt_q == STABLE);
        acc_bits = accept ? sel_q : 4'd0;
    end

    always_comb begin
        slot_data_d = slot_data_q;
        slot_err_d  = slot_err_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_bits[i]) begin
                slot_data_d[4*i +: 4] = glyph[3:0];
                slot_err_d[i]         = glyph[4];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        load     = 1'b0;
        odata_d  = odata_q;
        oerr_d   = oerr_q;
        ovalid_d = ovalid_q;
        ovf_d    = ovf_q;
        if (ovalid_q && out_ready) begin
            ovalid_d = 1'b0;
        end
        unique case (state_q)
            COLLECT: begin
                mask_d = mask_q | acc_bits;
            end
            COMPLETE: begin
                load   = !ovalid_q || out_ready;
                mask_d = acc_bits;
                if (load) begin
                    odata_d  = slot_data_q;
                    oerr_d   = slot_err_q;
                    ovalid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                mask_d = 4'd0;
            end
        endcase
        state_d = (mask_d == 4'hF) ? COMPLETE : COLLECT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            seg_q       <= '0;
            sel_q       <= '0;
            prev_seg_q  <= '0;
            prev_sel_q  <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            slot_data_q <= '0;
            slot_err_q  <= '0;
            odata_q     <= '0;
            oerr_q      <= '0;
            ovalid_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_in;
            sel_q       <= dig_sel;
            prev_seg_q  <= seg_q;
            prev_sel_q  <= sel_q;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            slot_data_q <= slot_data_d;
            slot_err_q  <= slot_err_d;
            odata_q     <= odata_d;
            oerr_q      <= oerr_d;
            ovalid_q    <= ovalid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_data  = odata_q;
    assign out_err   = oerr_q;
    assign out_valid = ovalid_q;
    assign overflow  = ovf_q;

endmodule
